// File: rtl/snn_run_sequencer.sv
// Purpose : sequences one SNN inference run: clear network, strobe timesteps,
//           count output spikes, then dump per-output counts to a count RAM.
// Latency : one CLEAR cycle, sim_time*(timestep_div+1) RUN cycles, NUM_OUTPUTS DUMP cycles.
// Backpressure: none; the count RAM must accept one write per DUMP cycle.
//
// Ports:
//   clk, rst (async, active-high)      clock and reset
//   start, abort                        run request / immediate termination
//   sim_time, timestep_div              run length in timesteps, cycles per timestep minus 1
//   spike_out                           output-neuron spikes, sampled on spike_en cycles
//   network_rst, spike_en, timestep     neuron-array reset, timestep strobe, completed timesteps
//   count_wr_en/addr/data               count RAM write port, active in DUMP
//   busy, done                          run in progress / results available
// Optional macro SNN_SEQ_WINNER_EN adds winner_idx, winner_count, winner_valid
// (arg-max of the dumped counts, lowest index wins ties).

module snn_run_sequencer #(
    parameter int NUM_OUTPUTS    = 4,
    parameter int COUNT_WIDTH    = 32,
    parameter int TIME_WIDTH     = 32,
    parameter int DIV_WIDTH      = 4,
    parameter int OUT_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [TIME_WIDTH-1:0]     sim_time,
    input  logic [DIV_WIDTH-1:0]      timestep_div,
    input  logic [NUM_OUTPUTS-1:0]    spike_out,
    output logic                      network_rst,
    output logic                      spike_en,
    output logic [TIME_WIDTH-1:0]     timestep,
    output logic                      count_wr_en,
    output logic [OUT_ADDR_WIDTH-1:0] count_wr_addr,
    output logic [COUNT_WIDTH-1:0]    count_wr_data,
    output logic                      busy,
    output logic                      done
`ifdef SNN_SEQ_WINNER_EN
    ,
    output logic [OUT_ADDR_WIDTH-1:0] winner_idx,
    output logic [COUNT_WIDTH-1:0]    winner_count,
    output logic                      winner_valid
`endif
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DUMP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [OUT_ADDR_WIDTH-1:0] LAST_IDX = OUT_ADDR_WIDTH'(NUM_OUTPUTS - 1);

    logic [2:0]                                state_q, state_d;
    logic [TIME_WIDTH-1:0]                     sim_time_q, sim_time_d;
    logic [DIV_WIDTH-1:0]                      div_q, div_d;
    logic [DIV_WIDTH-1:0]                      div_cnt_q, div_cnt_d;
    logic [TIME_WIDTH-1:0]                     timestep_q, timestep_d;
    logic [NUM_OUTPUTS-1:0][COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OUT_ADDR_WIDTH-1:0]                 dump_idx_q, dump_idx_d;

    logic                   strobe;
    logic [TIME_WIDTH-1:0]  timestep_inc;
    logic [COUNT_WIDTH-1:0] dump_data;

    assign strobe       = (state_q == ST_RUN) && (div_cnt_q == div_q);
    assign timestep_inc = timestep_q + TIME_WIDTH'(1);

    // Count selected by the dump pointer; written as a compare-mux so the
    // pointer width need not match the counter array depth.
    always_comb begin
        dump_data = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (dump_idx_q == OUT_ADDR_WIDTH'(i)) begin
                dump_data = cnt_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sim_time_d = sim_time_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        timestep_d = timestep_q;
        cnt_d      = cnt_q;
        dump_idx_d = dump_idx_q;

        if (abort) begin
            // Abort wins over everything, including a simultaneous start.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sim_time_d = sim_time;
                        div_d      = timestep_div;
                        state_d    = ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cnt_d      = '0;
                    timestep_d = '0;
                    div_cnt_d  = '0;
                    dump_idx_d = '0;
                    state_d    = (sim_time_q == '0) ? ST_DUMP : ST_RUN;
                end
                ST_RUN: begin
                    if (strobe) begin
                        div_cnt_d  = '0;
                        timestep_d = timestep_inc;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            // Saturate rather than wrap so a long run never under-reports.
                            if (spike_out[i] && (cnt_q[i] != '1)) begin
                                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
                            end
                        end
                        if (timestep_inc == sim_time_q) begin
                            state_d = ST_DUMP;
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                    end
                end
                ST_DUMP: begin
                    if (dump_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        dump_idx_d = dump_idx_q + OUT_ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sim_time_q <= '0;
            div_q      <= '0;
            div_cnt_q  <= '0;
            timestep_q <= '0;
            cnt_q      <= '0;
            dump_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sim_time_q <= sim_time_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            timestep_q <= timestep_d;
            cnt_q      <= cnt_d;
            dump_idx_q <= dump_idx_d;
        end
    end

    // network_rst also follows rst directly so the array is held in reset
    // together with the sequencer.
    assign network_rst   = rst || (state_q == ST_CLEAR);
    assign spike_en      = strobe;
    assign timestep      = timestep_q;
    // An abort in DUMP suppresses the write of that cycle as well.
    assign count_wr_en   = (state_q == ST_DUMP) && !abort;
    assign count_wr_addr = (state_q == ST_DUMP) ? dump_idx_q : '0;
    assign count_wr_data = (state_q == ST_DUMP) ? dump_data : '0;
    assign busy          = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_DUMP);
    assign done          = (state_q == ST_DONE);

`ifdef SNN_SEQ_WINNER_EN
    logic [OUT_ADDR_WIDTH-1:0] win_idx_q, win_idx_d;
    logic [COUNT_WIDTH-1:0]    win_cnt_q, win_cnt_d;
    logic                      win_vld_q, win_vld_d;

    always_comb begin
        win_idx_d = win_idx_q;
        win_cnt_d = win_cnt_q;
        // Valid exactly while the FSM sits in DONE.
        win_vld_d = (state_d == ST_DONE);
        if (state_q == ST_CLEAR) begin
            win_idx_d = '0;
            win_cnt_d = '0;
        end else if ((state_q == ST_DUMP) && !abort && (dump_data > win_cnt_q)) begin
            // Strict compare keeps the lowest index on ties.
            win_idx_d = dump_idx_q;
            win_cnt_d = dump_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx_q <= '0;
            win_cnt_q <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_idx_q <= win_idx_d;
            win_cnt_q <= win_cnt_d;
            win_vld_q <= win_vld_d;
        end
    end

    assign winner_idx   = win_idx_q;
    assign winner_count = win_cnt_q;
    assign winner_valid = win_vld_q;
`endif

endmodule

// File: tb/tb_snn_run_sequencer.sv
module tb_snn_run_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] sim_time;
    logic [3:0]  timestep_div;
    logic [3:0]  spike_out;

    logic        network_rst, spike_en, count_wr_en, busy, done;
    logic [31:0] timestep;
    logic [3:0]  count_wr_addr;
    logic [31:0] count_wr_data;

    logic        s_network_rst, s_spike_en, s_count_wr_en, s_busy, s_done;
    logic [31:0] s_timestep;
    logic [3:0]  s_count_wr_addr;
    logic [1:0]  s_count_wr_data;

`ifdef SNN_SEQ_WINNER_EN
    logic [3:0]  winner_idx;
    logic [31:0] winner_count;
    logic        winner_valid;
    logic [3:0]  s_winner_idx;
    logic [1:0]  s_winner_count;
    logic        s_winner_valid;
`endif

    snn_run_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sim_time(sim_time), .timestep_div(timestep_div), .spike_out(spike_out),
        .network_rst(network_rst), .spike_en(spike_en), .timestep(timestep),
        .count_wr_en(count_wr_en), .count_wr_addr(count_wr_addr),
        .count_wr_data(count_wr_data), .busy(busy), .done(done)
`ifdef SNN_SEQ_WINNER_EN
        , .winner_idx(winner_idx), .winner_count(winner_count), .winner_valid(winner_valid)
`endif
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    snn_run_sequencer #(.COUNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sim_time(sim_time), .timestep_div(timestep_div), .spike_out(spike_out),
        .network_rst(s_network_rst), .spike_en(s_spike_en), .timestep(s_timestep),
        .count_wr_en(s_count_wr_en), .count_wr_addr(s_count_wr_addr),
        .count_wr_data(s_count_wr_data), .busy(s_busy), .done(s_done)
`ifdef SNN_SEQ_WINNER_EN
        , .winner_idx(s_winner_idx), .winner_count(s_winner_count), .winner_valid(s_winner_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int                T;
        int                D;
        logic [7:0][3:0]   spk;        // spike pattern per strobe index
        int                abort_at;   // cycle after start (0 = CLEAR), -1 none
        logic [3:0][31:0]  exp_cnt;
        logic [3:0][1:0]   exp_sat;
        int                exp_writes;
        int                exp_run_len;
        int                exp_win_idx;
        int                exp_win_cnt;
    } vec_t;

    function automatic logic [3:0][31:0] cnt4(input int a, input int b, input int c, input int d);
        logic [3:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic logic [3:0][1:0] sat4(input int a, input int b, input int c, input int d);
        logic [3:0][1:0] r;
        r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
        return r;
    endfunction

    function automatic logic [31:0] rep(input logic [3:0] p);
        return {8{p}};
    endfunction

    function automatic vec_t mkv(input int T, input int D, input logic [31:0] spk, input int ab,
                                 input logic [3:0][31:0] c, input logic [3:0][1:0] s,
                                 input int w, input int rl, input int wi, input int wc);
        vec_t v;
        v.T = T; v.D = D; v.spk = spk; v.abort_at = ab;
        v.exp_cnt = c; v.exp_sat = s; v.exp_writes = w; v.exp_run_len = rl;
        v.exp_win_idx = wi; v.exp_win_cnt = wc;
        return v;
    endfunction

    // Observations from the most recent run_case.
    int got_cnt[4];
    int got_sat[4];
    int got_writes;
    int got_run_len;

    // One run from start to DONE (or abort), checked every cycle against a
    // timeline derived from the run rules: 1 CLEAR cycle, T*(D+1) RUN cycles
    // with a strobe on the last cycle of each timestep, 4 DUMP cycles, DONE.
    task automatic run_case(input int T, input int D, input logic [7:0][3:0] spk,
                            input bit rnd, input int abort_at);
        int  run_cycles;
        int  last;
        int  mc[4];
        int  strobes;
        int  best_idx;
        int  best_cnt;
        bit  aborted;
        run_cycles = T * (D + 1);
        last       = 1 + run_cycles + 4;
        strobes    = 0;
        aborted    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mc[i] = 0; got_cnt[i] = -1; got_sat[i] = -1;
        end
        got_writes  = 0;
        got_run_len = 0;

        @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b0; sim_time = T; timestep_div = 4'(D);
        @(posedge clk);
        for (int n = 0; n <= last; n++) begin
            bit is_run, stb, is_dump;
            int r, k, exp_ts;
            r       = n - 1;
            is_run  = (n >= 1) && (n <= run_cycles);
            stb     = is_run && ((r % (D + 1)) == D);
            k       = n - 1 - run_cycles;
            is_dump = (k >= 0) && (k < 4);
            exp_ts  = is_run ? (r / (D + 1)) : T;
            #1;
            start        = (n < last) ? 1'($urandom) : 1'b0;
            sim_time     = $urandom;
            timestep_div = 4'($urandom);
            spike_out    = rnd ? 4'($urandom) : spk[strobes % 8];
            abort        = (n == abort_at);
            @(negedge clk);
            if (stb) begin
                for (int i = 0; i < 4; i++) mc[i] += int'(spike_out[i]);
                strobes++;
            end
            check("busy", busy, longint'(n < last));
            check("done", done, longint'(n == last));
            check("network_rst", network_rst, longint'(n == 0));
            check("spike_en", spike_en, longint'(stb));
            if (n >= 1) check("timestep", timestep, exp_ts);
            if (n != abort_at) check("count_wr_en", count_wr_en, longint'(is_dump));
            if (is_dump) begin
                check("count_wr_addr", count_wr_addr, k);
                check("count_wr_data", count_wr_data, mc[k]);
                check("sat_wr_data", s_count_wr_data, (mc[k] > 3) ? 3 : mc[k]);
            end else begin
                check("count_wr_addr_idle", count_wr_addr, 0);
                check("count_wr_data_idle", count_wr_data, 0);
            end
            if (count_wr_en) begin
                got_writes++;
                got_cnt[count_wr_addr[1:0]] = int'(count_wr_data);
                got_sat[s_count_wr_addr[1:0]] = int'(s_count_wr_data);
            end
            if (busy && !network_rst && !count_wr_en) got_run_len++;
`ifdef SNN_SEQ_WINNER_EN
            check("winner_valid", winner_valid, longint'(n == last));
            if (n == last) begin
                best_idx = 0; best_cnt = 0;
                for (int i = 0; i < 4; i++) begin
                    if (mc[i] > best_cnt) begin best_cnt = mc[i]; best_idx = i; end
                end
                check("winner_idx", winner_idx, best_idx);
                check("winner_count", winner_count, best_cnt);
            end
`endif
            @(posedge clk);
            if (n == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        #1;
        start = 1'b0; abort = 1'b0;
        if (aborted) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_wr_en", count_wr_en, 0);
                check("abort_spike_en", spike_en, 0);
                check("abort_network_rst", network_rst, 0);
`ifdef SNN_SEQ_WINNER_EN
                check("abort_winner_valid", winner_valid, 0);
`endif
                got_writes += int'(count_wr_en);
                @(posedge clk);
                #1;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        sim_time = '0; timestep_div = '0; spike_out = '0;

        vecs[0] = mkv(3, 0, rep(4'b0101), -1, cnt4(3,0,3,0), sat4(3,0,3,0), 4, 3, 0, 3);
        vecs[1] = mkv(2, 2, rep(4'b1111), -1, cnt4(2,2,2,2), sat4(2,2,2,2), 4, 6, 0, 2);
        vecs[2] = mkv(0, 1, rep(4'b1111), -1, cnt4(0,0,0,0), sat4(0,0,0,0), 4, 0, 0, 0);
        vecs[3] = mkv(6, 0, rep(4'b0001), -1, cnt4(6,0,0,0), sat4(3,0,0,0), 4, 6, 0, 6);
        vecs[4] = mkv(5, 0, 32'h0006667F, -1, cnt4(2,5,5,1), sat4(2,3,3,1), 4, 5, 1, 5);
        vecs[5] = mkv(3, 0, rep(4'b1111), 2, cnt4(0,0,0,0), sat4(0,0,0,0), 0, 2, 0, 0);
        vecs[6] = mkv(4, 1, rep(4'b1010), -1, cnt4(0,4,0,4), sat4(0,3,0,3), 4, 8, 1, 4);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_network_rst", network_rst, 1);
        check("rst_spike_en", spike_en, 0);
        check("rst_wr_en", count_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", count_wr_addr, 0);
        check("rst_data", count_wr_data, 0);
        check("rst_timestep", timestep, 0);
`ifdef SNN_SEQ_WINNER_EN
        check("rst_winner_idx", winner_idx, 0);
        check("rst_winner_count", winner_count, 0);
        check("rst_winner_valid", winner_valid, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_network_rst", network_rst, 0);
        check("idle_busy", busy, 0);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            run_case(vecs[v].T, vecs[v].D, vecs[v].spk, 1'b0, vecs[v].abort_at);
            check($sformatf("vec%0d_writes", v), got_writes, vecs[v].exp_writes);
            check($sformatf("vec%0d_run_len", v), got_run_len, vecs[v].exp_run_len);
            if (vecs[v].exp_writes == 4) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("vec%0d_cnt%0d", v, k), got_cnt[k], vecs[v].exp_cnt[k]);
                    check($sformatf("vec%0d_sat%0d", v, k), got_sat[k], vecs[v].exp_sat[k]);
                end
            end
        end

        // Finish a run, then start and abort together while in DONE.
        run_case(2, 0, rep(4'b0011), 1'b0, -1);
        @(negedge clk);
        check("done_hold", done, 1);
        check("done_timestep_hold", timestep, 2);
        @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_done", done, 0);
        check("start_abort_busy", busy, 0);
        check("start_abort_network_rst", network_rst, 0);
        @(negedge clk);
        check("start_abort_stays_idle", busy, 0);

        // Randomised runs against the timeline model.
        for (int it = 0; it < 25; it++) begin
            int T, D, ab;
            T  = $urandom_range(0, 6);
            D  = $urandom_range(0, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + T * (D + 1) + 3) : -1;
            run_case(T, D, '0, 1'b1, ab);
        end

        // Reset in the middle of a run discards it.
        @(posedge clk);
        #1;
        start = 1'b1; sim_time = 5; timestep_div = 4'd1;
        @(posedge clk);
        #1;
        start = 1'b0; spike_out = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_network_rst", network_rst, 1);
        check("midrst_busy", busy, 0);
        check("midrst_spike_en", spike_en, 0);
        check("midrst_timestep", timestep, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check("midrst_no_write", count_wr_en, 0);
            check("midrst_no_done", done, 0);
            check("midrst_idle", busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snn_run_sequencer.md
SNN_RUN_SEQUENCER -- requirements
Module: snn_run_sequencer

Interface
REQ-001 Parameter NUM_OUTPUTS, default 4: number of output neurons observed and counted.
REQ-002 Parameter COUNT_WIDTH, default 32: width of each per-output spike counter.
REQ-003 Parameter TIME_WIDTH, default 32: width of sim_time and timestep.
REQ-004 Parameter DIV_WIDTH, default 4: width of timestep_div.
REQ-005 Parameter OUT_ADDR_WIDTH, default 4: count RAM address width; must satisfy 2**OUT_ADDR_WIDTH >= NUM_OUTPUTS.
REQ-006 Reset is asynchronous, active-high; the block has one clock, clk.
REQ-007 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1: asynchronous active-high reset.
REQ-009 Port start, input, 1: one-cycle run request.
REQ-010 Port abort, input, 1: terminate the current run immediately.
REQ-011 Port sim_time, input, TIME_WIDTH: number of timesteps per run.
REQ-012 Port timestep_div, input, DIV_WIDTH: clock cycles per timestep, minus 1.
REQ-013 Port spike_out, input, NUM_OUTPUTS: network output spikes.
REQ-014 Port network_rst, output, 1: reset to the neuron array.
REQ-015 Port spike_en, output, 1: timestep strobe to the spike sources and network.
REQ-016 Port timestep, output, TIME_WIDTH: completed timestep count.
REQ-017 Port count_wr_en, output, 1: count RAM write enable.
REQ-018 Port count_wr_addr, output, OUT_ADDR_WIDTH: count RAM write address.
REQ-019 Port count_wr_data, output, COUNT_WIDTH: count RAM write data.
REQ-020 Port busy, output, 1: high in CLEAR, RUN and DUMP.
REQ-021 Port done, output, 1: high in DONE.

Function
REQ-022 FSM states: IDLE, CLEAR, RUN, DUMP, DONE.
REQ-023 In IDLE or DONE, start=1 captures sim_time and timestep_div into internal registers and moves to CLEAR; start is ignored in every other state.
REQ-024 CLEAR lasts exactly one cycle:
- network_rst=1
- all spike counters, timestep and the divider counter load 0
- next state RUN, or DUMP if the captured sim_time is 0.
REQ-025 In RUN, the divider counter counts 0..div and then wraps; spike_en=1 only in the cycle where divider==div, so the strobe period is div+1 cycles (div=0 gives spike_en high every cycle).
REQ-026 In each cycle with spike_en=1, counter[i] increments when spike_out[i]=1; counters saturate at all-ones and never wrap.
REQ-027 timestep increments on every spike_en cycle; when the incremented value equals the captured sim_time, the next state is DUMP.
REQ-028 DUMP lasts exactly NUM_OUTPUTS cycles; in cycle k:
- count_wr_en=1
- count_wr_addr=k
- count_wr_data=counter[k].
REQ-029 After the last DUMP write, the next state is DONE; done stays 1 until the next start or abort.
REQ-030 spike_en, network_rst and count_wr_en are 0 outside RUN, CLEAR and DUMP respectively.
REQ-031 abort=1 in any state forces IDLE on the next edge, with no further count RAM writes and done=0; abort takes priority over a simultaneous start.
REQ-032 Counters and timestep hold their values in IDLE and DONE.
REQ-033 Changes to sim_time or timestep_div during a run have no effect on that run.

Reset
REQ-034 While rst=1:
- state=IDLE
- all counters, timestep and captured registers are 0
- spike_en, count_wr_en, busy and done are 0
- count_wr_addr and count_wr_data are 0
- network_rst=1.
REQ-035 Reset asserted mid-run discards the run without completing DUMP.

Configuration
REQ-036 With macro SNN_SEQ_WINNER_EN defined, the block adds these outputs:
- winner_idx, OUT_ADDR_WIDTH
- winner_count, COUNT_WIDTH
- winner_valid, 1.
REQ-037 Under SNN_SEQ_WINNER_EN, winner tracking runs during DUMP:
- a running maximum is kept; the lowest index wins ties
- the result is registered, and winner_valid=1 in DONE
- all three winner outputs reset to 0 and clear in CLEAR.
REQ-038 Without the macro, these ports and their logic do not exist.

Verification
REQ-039 sim_time=3, div=0, spike_out=4'b0101 held: spike_en high for 3 consecutive RUN cycles; DUMP writes the counts {3,0,3,0} to addresses 0..3; done=1 after that.
REQ-040 sim_time=2, div=2: spike_en pulses occur 3 cycles apart, and RUN lasts 6 cycles.
REQ-041 sim_time=0: the sequence is CLEAR then DUMP, and four writes of 0 occur.
REQ-042 abort in RUN at timestep=1: IDLE on the next cycle, no count_wr_en, busy=0, done=0.
REQ-043 COUNT_WIDTH=2, sim_time=6, spike_out[0]=1: the count written to address 0 is 3 (saturated).
REQ-044 SNN_SEQ_WINNER_EN, counts {2,5,5,1}: winner_idx=1, winner_count=5, winner_valid=1 in DONE.
